rule_scheduler: RTL

Round-robin rule scheduler that sits directly upstream of the generated Murphi `system` block. It samples the per-rule guard vector the system exposes and drives the system's one-hot rule-enable input `io_en_a`, firing one enabled rule at a time. It alternates issue and settle cycles so that every guard sample reflects the state after the previous firing. It also runs a starvation watchdog and a deadlock watchdog used by the equivalence-check harness.

---
 rtl/rule_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rule_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rule_scheduler : round-robin one-hot rule issuer with starvation/deadlock watchdogs
// Revision 1.0
// ---------------------------------------------------------------------------
module rule_scheduler #(
   parameter int NUM_RULES      = 4,
   parameter int STARVE_LIMIT   = 8,
   parameter int DEADLOCK_LIMIT = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_RULES-1:0] io_guard,
   input  logic                 io_hold,
   output logic [NUM_RULES-1:0] io_en_a,
   output logic [15:0]          io_fire_count,
   output logic [NUM_RULES-1:0] io_starve,
   output logic                 io_deadlock
);

   localparam int PTR_W  = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
   localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
   localparam int IDLE_W = $clog2(DEADLOCK_LIMIT + 1);

   typedef enum logic [0:0] {
      S_SAMPLE = 1'b0,
      S_ISSUE  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [IDLE_W-1:0]    idle_q, idle_d;
   logic [15:0]          fire_q, fire_d;
   logic [NUM_RULES-1:0] en_q, en_d;
   logic                 dead_q, dead_d;

   logic                 found;
   logic [PTR_W-1:0]     grant;
   logic                 issue;

   // First requesting rule at or after ptr, wrapping around.
   always_comb begin : p_grant
      int idx;
      idx   = 0;
      found = 1'b0;
      grant = '0;
      for (int k = 0; k < NUM_RULES; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_RULES) idx = idx - NUM_RULES;
         if (!found && io_guard[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            grant = idx[PTR_W-1:0];
         end
      end
   end

   assign issue = (state_q == S_SAMPLE) && !io_hold && found;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idle_d  = idle_q;
      fire_d  = fire_q;
      en_d    = '0;
      dead_d  = dead_q;
      case (state_q)
         S_SAMPLE: begin
            if (!io_hold) begin
               if (found) begin
                  en_d    = NUM_RULES'(1) << grant;
                  ptr_d   = (grant == PTR_W'(NUM_RULES - 1)) ? '0 : grant + 1'b1;
                  if (fire_q != 16'hFFFF) fire_d = fire_q + 16'd1;
                  idle_d  = '0;
                  state_d = S_ISSUE;
               end else begin
                  if (idle_q != IDLE_W'(DEADLOCK_LIMIT)) idle_d = idle_q + 1'b1;
                  if (idle_d == IDLE_W'(DEADLOCK_LIMIT)) dead_d = 1'b1;
               end
            end
         end
         S_ISSUE:  state_d = S_SAMPLE;
         default:  state_d = S_SAMPLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_SAMPLE;
         ptr_q   <= '0;
         idle_q  <= '0;
         fire_q  <= '0;
         en_q    <= '0;
         dead_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idle_q  <= idle_d;
         fire_q  <= fire_d;
         en_q    <= en_d;
         dead_q  <= dead_d;
      end
   end

   generate
      for (genvar i = 0; i < NUM_RULES; i++) begin : g_wait
         logic [WAIT_W-1:0] wait_q, wait_d;
         logic              starve_q, starve_d;

         // Only a granting SAMPLE touches the wait counters.
         always_comb begin
            wait_d   = wait_q;
            starve_d = starve_q;
            if (issue) begin
               if (io_guard[i] && (grant != PTR_W'(i))) begin
                  if (wait_q != WAIT_W'(STARVE_LIMIT)) wait_d = wait_q + 1'b1;
                  if (wait_d == WAIT_W'(STARVE_LIMIT)) starve_d = 1'b1;
               end else begin
                  wait_d = '0;
               end
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               wait_q   <= '0;
               starve_q <= 1'b0;
            end else begin
               wait_q   <= wait_d;
               starve_q <= starve_d;
            end
         end

         assign io_starve[i] = starve_q;
      end
   endgenerate

   assign io_en_a       = en_q;
   assign io_fire_count = fire_q;
   assign io_deadlock   = dead_q;

endmodule
`default_nettype wire
